api_nonce_filter: RTL

- Sits between api_ctrl's result outputs (rx_fifo_wr_en / rx_fifo_din) and the 512-word rx_fifo.
- Groups incoming result words into fixed-length records and checks each record's nonce word against a small history of recently forwarded nonces.
- Drops duplicates; forwards new records into the rx FIFO only when the whole record fits.
- Keeps saturating drop and overflow counters for the wishbone slave to expose.

---
 rtl/api_nonce_filter_pkg.sv | 15 +
 rtl/api_nonce_filter_if.sv | 13 +
 rtl/api_nonce_filter_hist.sv | 44 ++++
 rtl/api_nonce_filter.sv | 95 +++++++++
 4 files changed

// File: rtl/api_nonce_filter_pkg.sv
// Shared types, FSM encoding and counter helper for the result-record nonce filter.
package api_nf_pkg;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 16;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (&v) ? v : cnt_t'(v + 1'b1);
  endfunction
endpackage

// File: rtl/api_nonce_filter_if.sv
// Result-word stream from api_ctrl plus the push side and fill level of rx_fifo.
interface api_nf_if;
  import api_nf_pkg::*;

  logic       in_wr_en;
  word_t      in_din;
  logic       out_wr_en;
  word_t      out_din;
  logic [9:0] out_cnt;

  modport slave  (input  in_wr_en, in_din, out_cnt, output out_wr_en, out_din);
  modport master (output in_wr_en, in_din, out_cnt, input  out_wr_en, out_din);
endinterface

// File: rtl/api_nonce_filter_hist.sv
// Round-robin history of recently forwarded nonces with a combinational membership test.
module api_nonce_hist
  import api_nf_pkg::*;
#(
  parameter int HIST_DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  word_t nonce,
  input  logic  insert,
  output logic  hit
);
  localparam int PTR_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

  word_t                 entry [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] valid;
  logic [PTR_W-1:0]      wr_ptr;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      if (valid[i] && (entry[i] == nonce)) hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= '0;
      wr_ptr <= '0;
    end else if (clr) begin
      valid  <= '0;
      wr_ptr <= '0;
    end else if (insert) begin
      valid[wr_ptr] <= 1'b1;
      wr_ptr        <= (wr_ptr == PTR_W'(HIST_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
    end
  end

  // Entry payload is qualified by valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (insert && !clr) entry[wr_ptr] <= nonce;
  end
endmodule

// File: rtl/api_nonce_filter.sv
// Groups result words into records, drops duplicate nonces and records that would not fit rx_fifo.
module api_nonce_filter
  import api_nf_pkg::*;
#(
  parameter int REC_LEN    = 2,
  parameter int NONCE_IDX  = 0,
  parameter int HIST_DEPTH = 8,
  parameter int FIFO_DEPTH = 512
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  input  logic     filt_en,
  api_nf_if.slave  bus,
  output cnt_t     drop_cnt,
  output cnt_t     ovf_cnt,
  output logic     busy
);
  localparam int               IDX_W = (REC_LEN > 1) ? $clog2(REC_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(REC_LEN-1);

  logic [IDX_W-1:0] widx, eidx;
  logic [0:0]       state;
  word_t            cap_buf  [REC_LEN];
  word_t            emit_buf [REC_LEN];
  word_t            rec      [REC_LEN];
  word_t            nonce;
  logic             decide, hist_hit, hit, room, accept;
  logic [10:0]      cnt11, free11;

  // The final word of a record is still on in_din during the decision cycle.
  always_comb begin
    for (int i = 0; i < REC_LEN; i++) begin
      rec[i] = (i == REC_LEN-1) ? bus.in_din : cap_buf[i];
    end
    nonce = rec[NONCE_IDX];
  end

  assign decide = bus.in_wr_en && !flush && (widx == LAST);
  assign cnt11  = {1'b0, bus.out_cnt};
  assign free11 = (cnt11 >= 11'(FIFO_DEPTH)) ? 11'd0 : 11'(FIFO_DEPTH) - cnt11;
  assign room   = (free11 >= 11'(REC_LEN));
  assign hit    = filt_en && hist_hit;
  assign accept = decide && !hit && room;

  api_nonce_hist #(.HIST_DEPTH(HIST_DEPTH)) u_hist (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (flush),
    .nonce  (nonce),
    .insert (accept && filt_en),
    .hit    (hist_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx     <= '0;
      eidx     <= '0;
      state    <= ST_IDLE;
      drop_cnt <= '0;
      ovf_cnt  <= '0;
    end else if (flush) begin
      widx     <= '0;
      eidx     <= '0;
      state    <= ST_IDLE;
      drop_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      if (bus.in_wr_en) widx <= (widx == LAST) ? '0 : widx + 1'b1;
      if (decide && hit)                drop_cnt <= sat_inc(drop_cnt);
      else if (decide && !room)         ovf_cnt  <= sat_inc(ovf_cnt);
      // A new record accepted on the last emit cycle restarts the burst without a gap.
      if (accept) begin
        state <= ST_EMIT;
        eidx  <= '0;
      end else if (state == ST_EMIT) begin
        if (eidx == LAST) begin
          state <= ST_IDLE;
          eidx  <= '0;
        end else begin
          eidx <= eidx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.in_wr_en && !flush) cap_buf[widx] <= bus.in_din;
    if (accept)                 emit_buf      <= rec;
  end

  assign bus.out_wr_en = (state == ST_EMIT);
  assign bus.out_din   = bus.out_wr_en ? emit_buf[eidx] : '0;
  assign busy          = bus.out_wr_en;
endmodule
